// File: rtl/obi_sram_slave_if.sv
// OBI A/R channel bundle between a manager and the SRAM subordinate.
// Carries request, write payload and in-order response signals.
interface obi_sram_slave_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    req;
    logic                    gnt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    err;

    modport master (
        output req,
        output addr,
        output we,
        output be,
        output wdata,
        output rready,
        input  gnt,
        input  rvalid,
        input  rdata,
        input  err
    );

    modport slave (
        input  req,
        input  addr,
        input  we,
        input  be,
        input  wdata,
        input  rready,
        output gnt,
        output rvalid,
        output rdata,
        output err
    );
endinterface

// File: rtl/obi_sram_slave.sv
// OBI scratch-memory subordinate with byte-enable writes and a
// response FIFO allowing MAX_OUTSTANDING pipelined transactions.
module obi_sram_slave #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MEM_DEPTH       = 16,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [63:0] ERR_RDATA       = 64'hBADCAB1E
) (
    input logic           clk_i,
    input logic           reset_i,
    obi_sram_slave_if.slave obi
);

    localparam int unsigned BW  = DATA_WIDTH / 8;
    localparam int unsigned OFF = $clog2(BW);
    localparam int unsigned IW  = $clog2(MEM_DEPTH);
    localparam int unsigned PW  =
        (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [DATA_WIDTH-1:0] fifo_rdata [MAX_OUTSTANDING];
    logic                  fifo_err   [MAX_OUTSTANDING];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    logic [IW-1:0]         idx;
    logic                  out_of_range;
    logic                  gnt;
    logic                  accept;
    logic                  pop;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] push_rdata;
    logic                  push_err;
    logic                  unused_addr_lsb;

    // Byte offset within a word carries no meaning for this target.
    assign unused_addr_lsb = ^obi.addr[OFF-1:0];

    assign idx          = obi.addr[OFF +: IW];
    assign out_of_range = |obi.addr[ADDR_WIDTH-1:OFF+IW];

    // Grant is a function of registered occupancy only.
    assign gnt    = !reset_i && (count < CNT_MAX);
    assign accept = obi.req && gnt;
    assign rvalid = (count != '0);
    assign pop    = rvalid && obi.rready;

    always_comb begin
        push_rdata = '0;
        push_err   = out_of_range;
        if (!obi.we) begin
            if (out_of_range) begin
                push_rdata = ERR_RDATA[DATA_WIDTH-1:0];
            end else begin
                push_rdata = mem[idx];
            end
        end
    end

    function automatic logic [PW-1:0] ptr_inc(
        input logic [PW-1:0] p
    );
        if (p == PTR_LAST) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Memory contents survive reset by design.
    always_ff @(posedge clk_i) begin
        if (accept && obi.we && !out_of_range) begin
            for (int b = 0; b < BW; b++) begin
                if (obi.be[b]) begin
                    mem[idx][8*b +: 8] <= obi.wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            fifo_rdata[wr_ptr] <= push_rdata;
            fifo_err[wr_ptr]   <= push_err;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign obi.gnt    = gnt;
    assign obi.rvalid = rvalid;
    assign obi.rdata  = rvalid ? fifo_rdata[rd_ptr] : '0;
    assign obi.err    = rvalid ? fifo_err[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_obi_sram_slave.sv
// Bench for obi_sram_slave: vector table plus response scoreboard.
// Inputs change 1ns after rising edges; responses sampled on falling edges.
module tb_obi_sram_slave;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    rsp_t sb [$];
    vec_t tbl [$];

    obi_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    obi_sram_slave #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .MEM_DEPTH      (16),
        .MAX_OUTSTANDING(2),
        .ERR_RDATA      (64'hBADCAB1E)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .obi    (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic vec_t v(logic [31:0] a, logic w, logic [3:0] b,
                               logic [31:0] d, logic [31:0] r, logic e);
        vec_t t;
        t.addr = a; t.we = w; t.be = b;
        t.wdata = d; t.rdata = r; t.err = e;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(vec_t t);
        rsp_t r;
        r.rdata = t.rdata;
        r.err   = t.err;
        sb.push_back(r);
    endtask

    task automatic drive(vec_t t);
        bus.req   = 1'b1;
        bus.addr  = t.addr;
        bus.we    = t.we;
        bus.be    = t.be;
        bus.wdata = t.wdata;
    endtask

    task automatic issue(vec_t t, output int waited);
        waited = 0;
        drive(t);
        while (!bus.gnt && waited < 20) begin
            step();
            waited++;
        end
        if (!bus.gnt) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: addr %h never granted", t.addr);
        end else begin
            push_exp(t);
            step();
        end
        bus.req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.rready = 1'b1;
        while (sb.size() != 0 && n < 50) begin
            step();
            n++;
        end
        chk("drain_left", sb.size(), 0);
        chk("idle_rvalid", bus.rvalid, 0);
        chk("idle_rdata", bus.rdata, 0);
        chk("idle_err", bus.err, 0);
    endtask

    // Scoreboard: a response is consumed on the edge after this sample.
    always @(negedge clk) begin
        rsp_t e;
        if (!rst && bus.rvalid && bus.rready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got %h expected none",
                         bus.rdata);
            end else begin
                e = sb.pop_front();
                chk("rsp_rdata", bus.rdata, e.rdata);
                chk("rsp_err", bus.err, e.err);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w;

        bus.req = 1'b0;
        bus.addr = '0;
        bus.we = 1'b0;
        bus.be = '0;
        bus.wdata = '0;
        bus.rready = 1'b1;

        for (int i = 0; i < 8; i++)
            tbl.push_back(v(32'(i * 4), 1, 4'hF, 32'h100 + i, 0, 0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(v(32'(i * 4), 0, 4'h0, 0, 32'h100 + i, 0));
        tbl.push_back(v(32'h08, 1, 4'hF, 32'h11223344, 0, 0));
        tbl.push_back(v(32'h08, 1, 4'h5, 32'hAABBCCDD, 0, 0));
        tbl.push_back(v(32'h08, 0, 4'h0, 0, 32'h11BB33DD, 0));
        tbl.push_back(v(32'h40, 1, 4'hF, 32'hFFFFFFFF, 0, 1));
        tbl.push_back(v(32'h40, 0, 4'hF, 0, 32'hBADCAB1E, 1));
        tbl.push_back(v(32'h00, 0, 4'h0, 0, 32'h100, 0));
        tbl.push_back(v(32'h24, 1, 4'hF, 32'h55667788, 0, 0));
        tbl.push_back(v(32'h24, 1, 4'h0, 32'hDEADBEEF, 0, 0));
        tbl.push_back(v(32'h24, 0, 4'h0, 0, 32'h55667788, 0));
        tbl.push_back(v(32'h25, 0, 4'h3, 0, 32'h55667788, 0));
        tbl.push_back(v(32'h10000000, 1, 4'hF, 32'h1, 0, 1));
        tbl.push_back(v(32'h10000004, 0, 4'h0, 0, 32'hBADCAB1E, 1));
        tbl.push_back(v(32'h0C, 0, 4'h0, 0, 32'h103, 0));

        // Reset held for three cycles.
        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt", bus.gnt, 0);
            chk("rst_rvalid", bus.rvalid, 0);
            chk("rst_rdata", bus.rdata, 0);
            chk("rst_err", bus.err, 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("post_rst_gnt", bus.gnt, 1);
        step();

        // Table vectors, back to back with rready high.
        foreach (tbl[i]) begin
            if (i >= 9 && i <= 15) begin
                chk("stream_rvalid", bus.rvalid, 1);
            end
            issue(tbl[i], w);
            if (i >= 8 && i <= 15) begin
                chk("stream_wait", w, 0);
            end
        end
        drain();

        // Response latency: rvalid the cycle after accept.
        drive(v(32'h08, 0, 4'h0, 0, 0, 0));
        chk("lat_pre_rvalid", bus.rvalid, 0);
        chk("lat_gnt", bus.gnt, 1);
        push_exp(v(0, 0, 0, 0, 32'h11BB33DD, 0));
        step();
        bus.req = 1'b0;
        chk("lat_rvalid", bus.rvalid, 1);
        chk("lat_rdata", bus.rdata, 32'h11BB33DD);
        drain();

        // Backpressure until full, then a single pop.
        bus.rready = 1'b0;
        issue(v(32'h00, 0, 4'h0, 0, 32'h100, 0), w);
        issue(v(32'h04, 0, 4'h0, 0, 32'h101, 0), w);
        drive(v(32'h08, 0, 4'h0, 0, 0, 0));
        chk("full_gnt", bus.gnt, 0);
        chk("stall_rdata", bus.rdata, 32'h100);
        step();
        chk("full_gnt2", bus.gnt, 0);
        chk("stall_rdata2", bus.rdata, 32'h100);
        bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
        chk("gnt_after_pop", bus.gnt, 1);
        push_exp(v(0, 0, 0, 0, 32'h11BB33DD, 0));
        step();
        bus.req = 1'b0;
        chk("head_after_pop", bus.rdata, 32'h101);
        chk("full_again_gnt", bus.gnt, 0);
        drain();

        // Asynchronous reset with two responses queued.
        bus.rready = 1'b0;
        issue(v(32'h00, 0, 4'h0, 0, 32'h100, 0), w);
        issue(v(32'h04, 0, 4'h0, 0, 32'h101, 0), w);
        chk("pre_rst_rvalid", bus.rvalid, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_rvalid", bus.rvalid, 0);
        chk("mid_rst_gnt", bus.gnt, 0);
        chk("mid_rst_rdata", bus.rdata, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("rel_gnt", bus.gnt, 1);
        step();
        bus.rready = 1'b1;
        issue(v(32'h08, 0, 4'h0, 0, 32'h11BB33DD, 0), w);
        issue(v(32'h1C, 0, 4'h0, 0, 32'h107, 0), w);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/obi_sram_slave.md
Name: obi_sram_slave

Overview:
Parametrised OBI subordinate backed by a register-file memory. It is the next generation of the single-outstanding OBI slave. It adds configurable memory depth, byte-enable writes and pipelined acceptance of up to MAX_OUTSTANDING transactions. An in-order response FIFO absorbs R-channel backpressure. It sits behind the OBI manager/crossbar as a generic scratch memory target.

Parameters:
ADDR_WIDTH, 32, byte-address width; 32 or 64.
DATA_WIDTH, 32, data width; 32 or 64.
MEM_DEPTH, 16, number of DATA_WIDTH words; power of two, >=2.
MAX_OUTSTANDING, 2, response FIFO depth, i.e. max accepted-but-unanswered transactions; >=1.
ERR_RDATA, 'hBADCAB1E, rdata returned on an erroneous read; zero-extended to DATA_WIDTH.

Ports:
clk_i  in  1  clock, all state on rising edge
reset_i  in  1  asynchronous, active-high reset
obi_req_i  in  1  A-channel request
obi_gnt_o  out  1  A-channel grant
obi_addr_i  in  ADDR_WIDTH  byte address
obi_we_i  in  1  1 = write, 0 = read
obi_be_i  in  DATA_WIDTH/8  byte enables
obi_wdata_i  in  DATA_WIDTH  write data
obi_rvalid_o  out  1  R-channel valid
obi_rready_i  in  1  R-channel ready
obi_rdata_o  out  DATA_WIDTH  read data
obi_err_o  out  1  transaction error

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-high on reset_i.
- Reset values while reset_i is high: obi_gnt_o=0, obi_rvalid_o=0, obi_rdata_o=0, obi_err_o=0. FIFO pointers and count are 0.
- Memory contents are not reset.
- Reset asserted mid-operation discards all queued responses immediately. Writes already committed to memory remain.
- Address decode:
  - OFF = log2(DATA_WIDTH/8).
  - idx = addr[OFF +: log2(MEM_DEPTH)].
  - out_of_range = |addr[ADDR_WIDTH-1 : OFF+log2(MEM_DEPTH)].
  - Low OFF bits are ignored.
- Grant: obi_gnt_o = !reset_i && (count < MAX_OUTSTANDING). It is combinational from registered state only, with no path from obi_req_i.
- Acceptance: a transaction is accepted on a rising edge where obi_req_i && obi_gnt_o.
- Write accept:
  - If in range, for each byte b with be[b]=1, mem[idx][8b+:8] <= wdata[8b+:8] on that edge.
  - be=0 leaves memory unchanged and still produces a normal response.
  - Out-of-range writes never modify memory.
  - Response pushed: rdata=0, err=out_of_range.
- Read accept:
  - mem[idx] is sampled on the accept edge and pushed as the response entry.
  - If out of range: rdata=ERR_RDATA, err=1. Otherwise rdata=mem[idx], err=0.
  - obi_be_i is ignored for reads; the full word is returned.
- Ordering:
  - Responses return strictly in acceptance order.
  - A read accepted the cycle after a write to the same word returns the written data.
  - Only one acceptance per cycle, so no same-edge read/write hazard exists.
- Latency: the earliest response is presented in the cycle after acceptance (rvalid rises one cycle after the accept edge). Accepts can be back-to-back, one per cycle, while count < MAX_OUTSTANDING.
- R channel:
  - obi_rvalid_o = (count != 0).
  - obi_rdata_o and obi_err_o show the FIFO head when rvalid=1, and are 0 when rvalid=0.
  - Pop on obi_rvalid_o && obi_rready_i.
  - Head rdata/err are stable while rvalid=1 and rready=0.
- FIFO:
  - Circular buffer of MAX_OUTSTANDING entries {rdata, err}, with wrapping read/write pointers and count 0..MAX_OUTSTANDING.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Full: gnt=0, so no push occurs. A pop while full frees the slot for the following cycle; gnt never depends on the current-cycle pop.
  - Empty: pop is impossible because rvalid=0.
- obi_rready_i may be held low indefinitely; the slave then stalls after MAX_OUTSTANDING accepts.
- Tie-offs: no optional OBI signals are implemented. Unused request fields are ignored when req=0.

Test Plan:
- Reset then idle: assert reset_i for 3 cycles, then release -> gnt=0/rvalid=0/rdata=0/err=0 during reset; gnt=1 on the first cycle after release.
- Byte-enable write/read: write addr 0x8, wdata 0x11223344, be=4'b1111, then addr 0x8, wdata 0xAABBCCDD, be=4'b0101, then read 0x8 -> read response 0x11BB33DD, err=0, rvalid one cycle after its accept.
- Out of range (MEM_DEPTH=16, 32-bit): write 0x40 with 0xFFFFFFFF, then read 0x40 -> write resp err=1, rdata=0; read resp rdata=0xBADCAB1E, err=1; read of 0x0 still returns its prior value.
- Backpressure/full (MAX_OUTSTANDING=2): rready=0, issue 3 back-to-back reads of 0x0, 0x4, 0x8 -> first two accepted, gnt=0 on the third cycle. Raise rready for one cycle -> one pop, gnt=1 the next cycle, third read accepted.
- Streaming: rready=1, 8 consecutive reads of words 0..7 (preloaded with 0x100+i) -> one accept per cycle, responses in order 0x100..0x107 with no bubbles; covers pointer wrap and simultaneous push/pop.
- Reset mid-operation: 2 responses queued with rready=0, then assert reset_i asynchronously between edges -> rvalid drops to 0 immediately; after release, a read of a word written before the reset returns the written value.
